// File: rtl/jtag_uart_responder.sv
// jtag_uart_responder: Avalon-MM slave modelling the JTAG UART register map.
// Host byte streams feed an RX FIFO (read by the initiator) and drain a TX FIFO.
// Define JTAG_UART_RESP_STALL_EN to add 0..3 pseudo-random extra WAIT cycles per access.
module jtag_uart_responder #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic [31:0] writedata,
    input  logic        write,
    input  logic        read,
    output logic        waitrequest,
    output logic [31:0] readdata,
    input  logic        host_rx_valid,
    input  logic [7:0]  host_rx_data,
    output logic        host_rx_ready,
    output logic        host_tx_valid,
    output logic [7:0]  host_tx_data,
    input  logic        host_tx_ready
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FullCnt = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PtrOne = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0] CntOne = (DEPTH_LOG2 + 1)'(1);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e state_q, state_d;
    logic [31:0] readdata_q, readdata_d;
    logic ac_q, ac_d;
    logic load_rd, wait_done;

    logic [7:0] rx_mem [Depth];
    logic [7:0] tx_mem [Depth];
    logic [DEPTH_LOG2-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [DEPTH_LOG2-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [DEPTH_LOG2:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;

    logic in_ack, is_data, rx_full, rx_empty, tx_full, tx_empty;
    logic rx_push, rx_pop, tx_push, tx_pop;
    logic [DEPTH_LOG2:0] rx_cnt_eff, ravail, wspace;
    logic rx_valid_eff;
    logic [7:0] rx_head_eff;
    logic unused_bits;

    assign unused_bits = ^{writedata[31:11], writedata[9:8], address[1:0]};

    assign in_ack   = (state_q == StAck);
    assign is_data  = ~address[2];
    assign rx_full  = (rx_cnt_q == FullCnt);
    assign rx_empty = (rx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == FullCnt);
    assign tx_empty = (tx_cnt_q == '0);

    assign host_rx_ready = ~rx_full;
    assign host_tx_valid = ~tx_empty;
    assign host_tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd_q];
    assign waitrequest   = ~in_ack;
    assign readdata      = readdata_q;

    // write wins over read, so a pop needs read without write
    assign rx_push = host_rx_valid & ~rx_full;
    assign rx_pop  = in_ack & read & ~write & is_data & ~rx_empty;
    assign tx_pop  = host_tx_valid & host_tx_ready;
    assign tx_push = in_ack & write & is_data & ~tx_full;

`ifdef JTAG_UART_RESP_STALL_EN
    logic [31:0] lfsr_q, lfsr_d;
    logic [1:0]  stall_q, stall_d;

    // Galois LFSR free-runs; its low bits seed the extra WAIT count on entry to WAIT
    always_comb begin
        lfsr_d  = lfsr_q[0] ? ((lfsr_q >> 1) ^ 32'h8020_0003) : (lfsr_q >> 1);
        stall_d = stall_q;
        if (state_q == StIdle && (read || write)) begin
            stall_d = lfsr_q[1:0];
        end else if (state_q == StWait && stall_q != 2'd0) begin
            stall_d = stall_q - 2'd1;
        end
    end

    assign wait_done = (stall_q == 2'd0);

    // stall state registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_q  <= 32'h1;
            stall_q <= 2'd0;
        end else begin
            lfsr_q  <= lfsr_d;
            stall_q <= stall_d;
        end
    end
`else
    assign wait_done = 1'b1;
`endif

    // access FSM: IDLE -> WAIT -> ACK, readdata captured on the WAIT->ACK edge
    always_comb begin
        state_d = state_q;
        load_rd = 1'b0;
        unique case (state_q)
            StIdle: if (read || write) state_d = StWait;
            StWait: begin
                if (wait_done) begin
                    state_d = StAck;
                    load_rd = 1'b1;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // read data and sticky AC; a host push in the capture cycle is already counted
    always_comb begin
        rx_cnt_eff   = rx_cnt_q + (rx_push ? CntOne : '0);
        rx_valid_eff = (rx_cnt_eff != '0);
        rx_head_eff  = rx_empty ? host_rx_data : rx_mem[rx_rd_q];
        ravail       = rx_cnt_eff - (rx_valid_eff ? CntOne : '0);
        wspace       = FullCnt - (tx_cnt_q - (tx_pop ? CntOne : '0));
        readdata_d   = readdata_q;
        if (load_rd) begin
            if (write) begin
                readdata_d = 32'h0;
            end else if (is_data) begin
                readdata_d = {16'(ravail), rx_valid_eff, 7'b0,
                              rx_valid_eff ? rx_head_eff : 8'h00};
            end else begin
                readdata_d = {16'(wspace), 5'b0, ac_q, 10'b0};
            end
        end
        ac_d = ac_q;
        if (in_ack && write && is_data && tx_full) begin
            ac_d = 1'b1;
        end else if (in_ack && write && !is_data && writedata[10]) begin
            ac_d = 1'b0;
        end
    end

    // FIFO pointers and counts
    always_comb begin
        rx_wr_d  = rx_push ? rx_wr_q + PtrOne : rx_wr_q;
        rx_rd_d  = rx_pop ? rx_rd_q + PtrOne : rx_rd_q;
        tx_wr_d  = tx_push ? tx_wr_q + PtrOne : tx_wr_q;
        tx_rd_d  = tx_pop ? tx_rd_q + PtrOne : tx_rd_q;
        rx_cnt_d = rx_cnt_q;
        tx_cnt_d = tx_cnt_q;
        unique case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + CntOne;
            2'b01:   rx_cnt_d = rx_cnt_q - CntOne;
            default: rx_cnt_d = rx_cnt_q;
        endcase
        unique case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + CntOne;
            2'b01:   tx_cnt_d = tx_cnt_q - CntOne;
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    // control state registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            readdata_q <= 32'h0;
            ac_q       <= 1'b0;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            readdata_q <= readdata_d;
            ac_q       <= ac_d;
            rx_wr_q    <= rx_wr_d;
            rx_rd_q    <= rx_rd_d;
            tx_wr_q    <= tx_wr_d;
            tx_rd_q    <= tx_rd_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
        end
    end

    // FIFO storage; contents are meaningless once the pointers reset
    always_ff @(posedge clock) begin
        if (rx_push) rx_mem[rx_wr_q] <= host_rx_data;
        if (tx_push) tx_mem[tx_wr_q] <= writedata[7:0];
    end

endmodule

// File: tb/tb_jtag_uart_responder.sv
// Bench for jtag_uart_responder: directed scenarios plus randomized traffic against
// a queue-based reference model.
module tb_jtag_uart_responder;

    localparam int DL = 2;
    localparam int D  = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic        write, read, waitrequest;
    logic [31:0] readdata;
    logic        host_rx_valid, host_rx_ready, host_tx_valid, host_tx_ready;
    logic [7:0]  host_rx_data, host_tx_data;

    always #5 clock = ~clock;

    jtag_uart_responder #(.DEPTH_LOG2(DL)) dut (
        .clock(clock), .reset(reset), .address(address), .writedata(writedata),
        .write(write), .read(read), .waitrequest(waitrequest), .readdata(readdata),
        .host_rx_valid(host_rx_valid), .host_rx_data(host_rx_data),
        .host_rx_ready(host_rx_ready), .host_tx_valid(host_tx_valid),
        .host_tx_data(host_tx_data), .host_tx_ready(host_tx_ready)
    );

    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic [7:0]  seen[$];
    bit          ac_m;
    logic [31:0] exp_rdata, ack_rdata, r;
    bit          acc_active, rand_host;
    int          age, rx_bias, tx_bias;
    int          n_vec = 0, n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read();
        if (write) return 32'h0;
        if (!address[2]) begin
            if (rxq.size() == 0) return 32'h0;
            return {16'(rxq.size() - 1), 1'b1, 7'b0, rxq[0]};
        end
        return {16'(D - txq.size()), 5'b0, ac_m, 10'b0};
    endfunction

    task automatic model_edge();
        bit do_push, do_pop, tx_full, ack;
        do_push = host_rx_valid && (rxq.size() < D);
        do_pop  = host_tx_ready && (txq.size() > 0);
        tx_full = (txq.size() == D);
        ack     = acc_active && age == 2;
        if (ack) begin
            if (write) begin
                if (!address[2]) begin
                    if (tx_full) ac_m = 1'b1;
                end else if (writedata[10]) ac_m = 1'b0;
            end else if (!address[2] && rxq.size() > 0) void'(rxq.pop_front());
        end
        if (do_pop) void'(txq.pop_front());
        if (ack && write && !address[2] && !tx_full) txq.push_back(writedata[7:0]);
        if (do_push) rxq.push_back(host_rx_data);
        if (acc_active && age == 1) exp_rdata = model_read();
        if (acc_active) begin
            age++;
            if (age == 3) acc_active = 1'b0;
        end
    endtask

    // one clock: check outputs at negedge, advance model at posedge, drive #1 later
    task automatic cycle();
        if (!acc_active && (read || write)) begin
            acc_active = 1'b1;
            age = 0;
        end
        @(negedge clock);
        check_eq("waitrequest", 32'(waitrequest), 32'(!(acc_active && age == 2)));
        check_eq("readdata", readdata, exp_rdata);
        check_eq("host_rx_ready", 32'(host_rx_ready), 32'(rxq.size() < D));
        check_eq("host_tx_valid", 32'(host_tx_valid), 32'(txq.size() > 0));
        check_eq("host_tx_data", 32'(host_tx_data), 32'(txq.size() > 0 ? txq[0] : 8'h00));
        if (acc_active && age == 2) ack_rdata = readdata;
        if (host_tx_valid && host_tx_ready) seen.push_back(host_tx_data);
        @(posedge clock);
        if (reset) model_edge();
        #1;
        if (rand_host) begin
            host_rx_valid = ($urandom_range(99) < rx_bias);
            host_rx_data  = 8'($urandom);
            host_tx_ready = ($urandom_range(99) < tx_bias);
        end
    endtask

    task automatic access(input bit rd, input bit wr, input logic [2:0] a,
                          input logic [31:0] wd, output logic [31:0] rdat);
        read = rd;
        write = wr;
        address = a;
        writedata = wd;
        for (int i = 0; i < 3; i++) cycle();
        read = 1'b0;
        write = 1'b0;
        rdat = ack_rdata;
    endtask

    initial begin
        reset = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        host_rx_valid = 1'b0; host_rx_data = '0; host_tx_ready = 1'b0;
        rand_host = 1'b0; exp_rdata = '0; ack_rdata = '0; ac_m = 1'b0;
        acc_active = 1'b0; age = 0; rx_bias = 50; tx_bias = 50;
        #3;
        check_eq("rst_waitrequest", 32'(waitrequest), 32'h1);
        check_eq("rst_readdata", readdata, 32'h0);
        check_eq("rst_rx_ready", 32'(host_rx_ready), 32'h1);
        check_eq("rst_tx_valid", 32'(host_tx_valid), 32'h0);
        check_eq("rst_tx_data", 32'(host_tx_data), 32'h0);
        @(posedge clock);
        #1 reset = 1'b1;
        cycle();

        // empty read
        access(1'b1, 1'b0, 3'd0, 32'h0, r);
        check_eq("empty_read", r, 32'h0000_0000);

        // two host bytes then three reads
        host_rx_valid = 1'b1; host_rx_data = 8'h41; cycle();
        host_rx_data = 8'h42; cycle();
        host_rx_valid = 1'b0;
        access(1'b1, 1'b0, 3'd0, 32'h0, r); check_eq("rd1", r, 32'h0001_8041);
        access(1'b1, 1'b0, 3'd0, 32'h0, r); check_eq("rd2", r, 32'h0000_8042);
        access(1'b1, 1'b0, 3'd0, 32'h0, r); check_eq("rd3", r, 32'h0000_0000);

        // TX path with host draining
        access(1'b1, 1'b0, 3'd4, 32'h0, r); check_eq("wspace_empty", r, 32'h0004_0000);
        seen.delete();
        host_tx_ready = 1'b1;
        access(1'b0, 1'b1, 3'd0, 32'h55, r);
        access(1'b0, 1'b1, 3'd0, 32'hAA, r);
        cycle(); cycle();
        check_eq("tx_seen_n", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            check_eq("tx_seen0", 32'(seen[0]), 32'h55);
            check_eq("tx_seen1", 32'(seen[1]), 32'hAA);
        end

        // overflow TX, sticky AC, clear, drain
        host_tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) access(1'b0, 1'b1, 3'd0, 32'(i), r);
        access(1'b1, 1'b0, 3'd4, 32'h0, r); check_eq("ctrl_full_ac", r, 32'h0000_0400);
        access(1'b0, 1'b1, 3'd4, 32'h0000_0400, r);
        access(1'b1, 1'b0, 3'd4, 32'h0, r); check_eq("ctrl_ac_clr", r, 32'h0000_0000);
        seen.delete();
        host_tx_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        check_eq("drain_n", 32'(seen.size()), 32'd4);
        if (seen.size() == 4) begin
            check_eq("drain_first", 32'(seen[0]), 32'h01);
            check_eq("drain_last", 32'(seen[3]), 32'h04);
        end
        host_tx_ready = 1'b0;

        // fill RX, read one, then push and pop together
        host_rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            host_rx_data = 8'(8'h10 + i);
            cycle();
        end
        check_eq("rx_full_ready", 32'(host_rx_ready), 32'h0);
        host_rx_valid = 1'b0;
        access(1'b1, 1'b0, 3'd0, 32'h0, r);
        check_eq("rx_ravail3", r, 32'h0003_8010);
        check_eq("rx_ready_back", 32'(host_rx_ready), 32'h1);
        read = 1'b1; address = 3'd0;
        cycle(); cycle();
        host_rx_valid = 1'b1; host_rx_data = 8'h77;
        cycle();
        read = 1'b0; host_rx_valid = 1'b0;
        access(1'b1, 1'b0, 3'd0, 32'h0, r);
        check_eq("rx_push_pop", r, 32'h0002_8012);

        // reset during WAIT of a DATA read with RX non-empty
        read = 1'b1; address = 3'd0;
        cycle();
        #2 reset = 1'b0;
        read = 1'b0;
        rxq.delete(); txq.delete(); ac_m = 1'b0; exp_rdata = '0; acc_active = 1'b0;
        cycle(); cycle();
        reset = 1'b1;
        cycle(); cycle();
        check_eq("post_rst_rx_ready", 32'(host_rx_ready), 32'h1);
        access(1'b1, 1'b0, 3'd0, 32'h0, r);
        check_eq("post_rst_read", r, 32'h0000_0000);

        // randomized traffic with shifting host biases
        rand_host = 1'b1;
        for (int it = 0; it < 1500; it++) begin
            if (it % 250 == 0) begin
                rx_bias = ((it / 250) % 2 == 0) ? 80 : 20;
                tx_bias = ((it / 500) % 2 == 0) ? 10 : 90;
            end
            if ($urandom_range(1) == 1) begin
                int sel;
                sel = $urandom_range(9);
                access(sel < 5 || sel == 9, sel >= 5, 3'($urandom), $urandom, r);
            end else begin
                cycle();
            end
        end
        rand_host = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
